// File: rtl/layer_clk_gate_sched.sv
// Sequences one-hot clock-gate enables through the MLP layers, with programmable on-time and gaps.
// Start is accepted at the sampling edge (latency 1); all outputs are flops; start outside IDLE is dropped.
module layer_clk_gate_sched #(
    parameter  int NUM_LAYERS = 3,
    parameter  int CNT_W      = 8,
    localparam int CL_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_W-1:0]      cycles_per_layer,
    input  logic [CNT_W-1:0]      gap_cycles,
    output logic [NUM_LAYERS-1:0] layer_en,
    output logic [CL_W-1:0]       cur_layer,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      n_lat_q, n_lat_d;
    logic [CNT_W-1:0]      g_lat_q, g_lat_d;
    logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
    logic [CL_W-1:0]       cur_layer_q, cur_layer_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [CNT_W-1:0]      n_eff;
    logic [CL_W-1:0]       next_layer;
    logic [NUM_LAYERS-1:0] next_en;
    logic                  last_layer;

    // A zero length would leave a layer with no enable cycle at all, so it is promoted to one.
    assign n_eff      = (cycles_per_layer == '0) ? CNT_W'(1) : cycles_per_layer;
    assign next_layer = cur_layer_q + CL_W'(1);
    assign next_en    = NUM_LAYERS'(1) << next_layer;
    assign last_layer = (cur_layer_q == CL_W'(NUM_LAYERS - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_lat_d     = n_lat_q;
        g_lat_d     = g_lat_q;
        layer_en_d  = layer_en_q;
        cur_layer_d = cur_layer_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = RUN;
                    n_lat_d     = n_eff;
                    g_lat_d     = gap_cycles;
                    cnt_d       = n_eff - CNT_W'(1);
                    layer_en_d  = NUM_LAYERS'(1);
                    cur_layer_d = '0;
                    busy_d      = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    layer_en_d = '0;
                    busy_d     = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (last_layer) begin
                    state_d    = DONE;
                    layer_en_d = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else if (g_lat_q != '0) begin
                    state_d    = GAP;
                    cnt_d      = g_lat_q - CNT_W'(1);
                    layer_en_d = '0;
                end else begin
                    // Hand the enable straight to the next layer so no cycle is two-hot or empty.
                    cnt_d       = n_lat_q - CNT_W'(1);
                    cur_layer_d = next_layer;
                    layer_en_d  = next_en;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d     = RUN;
                    cnt_d       = n_lat_q - CNT_W'(1);
                    cur_layer_d = next_layer;
                    layer_en_d  = next_en;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                layer_en_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_lat_q     <= '0;
            g_lat_q     <= '0;
            layer_en_q  <= '0;
            cur_layer_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_lat_q     <= n_lat_d;
            g_lat_q     <= g_lat_d;
            layer_en_q  <= layer_en_d;
            cur_layer_q <= cur_layer_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign layer_en  = layer_en_q;
    assign cur_layer = cur_layer_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
